add_stim_driver: RTL

Self-checking stimulus initiator for the 16-bit adder DUT (A, B -> C) used in the VPI wrapper test top. On `start` it drives a fixed pseudo-random sequence of operand pairs onto A/B and samples C a programmable number of cycles later. It compares each C against A+B mod 2^WIDTH and reports pass/fail, error count and first failing index. It replaces the hand-written initial-block stimulus in the skeleton top and makes runs repeatable under both plain simulation and VPI control.

---
 rtl/add_drv_pkg.sv | 22 ++
 rtl/add_drv_lfsr.sv | 36 +++
 rtl/add_stim_driver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/add_drv_pkg.sv
// Shared types and constants for the adder stimulus driver.
// The LFSR step lives here so the sequence has a single definition.
package add_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    DONE
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] FAIL_NONE = 16'hFFFF;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] v
  );
    return {1'b0, v[15:1]} ^
      (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/add_drv_lfsr.sv
// 16-bit right-shifting Galois LFSR.
// Load has priority over step.
module add_drv_lfsr
  import add_drv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 16'h0000;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/add_stim_driver.sv
// Drives LFSR operand pairs into an adder and checks C
// against A+B after LATENCY+1 edges.
module add_stim_driver
  import add_drv_pkg::*;
#(
  parameter int          WIDTH    = 16,
  parameter int          LATENCY  = 0,
  parameter int          NUM_VECS = 256,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_fail,
  output logic [15:0]      vec_idx
);

  localparam logic [15:0] LAST = 16'(NUM_VECS - 1);
  localparam logic [15:0] LAT  = 16'(LATENCY);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum;
  logic [15:0]      vec_q, vec_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      ff_q, ff_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      lfsr_val;
  logic [15:0]      lfsr_nxt;
  logic             load;
  logic             step;
  logic             cmp;

  add_drv_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .seed  (SEED),
    .step  (step),
    .value (lfsr_val)
  );

  // WIDTH-bit add: the carry falls off
  assign sum      = a_q + b_q;
  assign lfsr_nxt = lfsr_next(lfsr_val);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ff_d    = ff_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    cmp     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          a_d     = WIDTH'(SEED);
          b_d     = '0;
          vec_d   = 16'h0000;
          err_d   = 16'h0000;
          ff_d    = FAIL_NONE;
          load    = 1'b1;
        end
      end
      DRIVE: begin
        if (LATENCY == 0) begin
          cmp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 16'd1;
        cmp   = (cnt_q == 16'd1);
      end
      default: state_d = IDLE;
    endcase
    if (cmp) begin
      if (C != sum) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (ff_q == FAIL_NONE) ff_d = vec_q;
      end
      if (vec_q == LAST) begin
        state_d = DONE;
      end else begin
        state_d = DRIVE;
        step    = 1'b1;
        a_d     = WIDTH'(lfsr_nxt);
        b_d     = WIDTH'(vec_q + 16'd1);
        vec_d   = vec_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      vec_q   <= 16'h0000;
      err_q   <= 16'h0000;
      ff_q    <= FAIL_NONE;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign busy       = (state_q == DRIVE) || (state_q == WAIT);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == 16'h0000);
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign vec_idx    = vec_q;

endmodule
